// File: rtl/ysyx_22050710_regfile_pkg.sv
// Shared constants for the regfile: CSR map, reset/trap values, bus layout.
// Bypass build option: YSYX_22050710_RF_BYPASS_EN.
package ysyx_22050710_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [63:0] MSTATUS_RST  = 64'h0000_000A_0000_1800;
    localparam logic [63:0] ECALL_MCAUSE = 64'd11;

    // Bus is {gpr_wen, gpr_waddr, gpr_wdata, csr_wen, csr_waddr, csr_wdata}.
    function automatic int bus_off_csr_waddr(int cw);
        return cw;
    endfunction

    function automatic int bus_off_csr_wen(int caw, int cw);
        return cw + caw;
    endfunction

    function automatic int bus_off_gpr_wdata(int caw, int cw);
        return cw + caw + 1;
    endfunction

    function automatic int bus_off_gpr_waddr(int gw, int caw, int cw);
        return cw + caw + 1 + gw;
    endfunction

    function automatic int bus_off_gpr_wen(int gaw, int gw, int caw, int cw);
        return cw + caw + 1 + gw + gaw;
    endfunction

    localparam int OFF_CSR_WDATA = 0;
    localparam int OFF_CSR_WADDR = bus_off_csr_waddr(64);
    localparam int OFF_CSR_WEN   = bus_off_csr_wen(12, 64);
    localparam int OFF_GPR_WDATA = bus_off_gpr_wdata(12, 64);
    localparam int OFF_GPR_WADDR = bus_off_gpr_waddr(64, 12, 64);
    localparam int OFF_GPR_WEN   = bus_off_gpr_wen(5, 64, 12, 64);

endpackage

// File: rtl/ysyx_22050710_regfile_if.sv
// Write-back bus, GPR/CSR read ports and trap signals of the regfile.
// Bypass build option: YSYX_22050710_RF_BYPASS_EN.
interface ysyx_22050710_regfile_if #(
    parameter int GPR_ADDR_WD     = 5,
    parameter int GPR_WD          = 64,
    parameter int CSR_ADDR_WD     = 12,
    parameter int CSR_WD          = 64,
    parameter int WS_TO_RF_BUS_WD = 1 + GPR_ADDR_WD + GPR_WD
                                  + 1 + CSR_ADDR_WD + CSR_WD
);

    logic [WS_TO_RF_BUS_WD-1:0] i_ws_to_rf_bus;
    logic [GPR_ADDR_WD-1:0]     i_raddr1;
    logic [GPR_ADDR_WD-1:0]     i_raddr2;
    logic [GPR_WD-1:0]          o_rdata1;
    logic [GPR_WD-1:0]          o_rdata2;
    logic [CSR_ADDR_WD-1:0]     i_csr_raddr;
    logic [CSR_WD-1:0]          o_csr_rdata;
    logic                       i_ecall;
    logic [CSR_WD-1:0]          i_ecall_pc;
    logic [CSR_WD-1:0]          o_mtvec;
    logic [CSR_WD-1:0]          o_mepc;

    modport master (
        output i_ws_to_rf_bus, i_raddr1, i_raddr2,
        output i_csr_raddr, i_ecall, i_ecall_pc,
        input  o_rdata1, o_rdata2, o_csr_rdata,
        input  o_mtvec, o_mepc
    );

    modport slave (
        input  i_ws_to_rf_bus, i_raddr1, i_raddr2,
        input  i_csr_raddr, i_ecall, i_ecall_pc,
        output o_rdata1, o_rdata2, o_csr_rdata,
        output o_mtvec, o_mepc
    );

endinterface

// File: rtl/ysyx_22050710_regfile_csrfile.sv
// Machine-mode CSR storage, ecall trap update and CSR read mux.
// Bypass build option: YSYX_22050710_RF_BYPASS_EN.
module ysyx_22050710_csrfile
    import ysyx_22050710_pkg::*;
#(
    parameter int CSR_ADDR_WD = 12,
    parameter int CSR_WD      = 64
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_wen,
    input  logic [CSR_ADDR_WD-1:0] i_waddr,
    input  logic [CSR_WD-1:0]      i_wdata,
    input  logic [CSR_ADDR_WD-1:0] i_raddr,
    output logic [CSR_WD-1:0]      o_rdata,
    input  logic                   i_ecall,
    input  logic [CSR_WD-1:0]      i_ecall_pc,
    output logic [CSR_WD-1:0]      o_mtvec,
    output logic [CSR_WD-1:0]      o_mepc
);

    localparam logic [CSR_ADDR_WD-1:0] A_MSTATUS = CSR_ADDR_WD'(CSR_MSTATUS);
    localparam logic [CSR_ADDR_WD-1:0] A_MTVEC   = CSR_ADDR_WD'(CSR_MTVEC);
    localparam logic [CSR_ADDR_WD-1:0] A_MEPC    = CSR_ADDR_WD'(CSR_MEPC);
    localparam logic [CSR_ADDR_WD-1:0] A_MCAUSE  = CSR_ADDR_WD'(CSR_MCAUSE);

    logic [CSR_WD-1:0] mstatus_q, mstatus_d;
    logic [CSR_WD-1:0] mtvec_q, mtvec_d;
    logic [CSR_WD-1:0] mepc_q, mepc_d;
    logic [CSR_WD-1:0] mcause_q, mcause_d;

    always_comb begin
        mstatus_d = mstatus_q;
        mtvec_d   = mtvec_q;
        mepc_d    = mepc_q;
        mcause_d  = mcause_q;
        if (i_wen) begin
            unique case (1'b1)
                i_waddr == A_MSTATUS: mstatus_d = i_wdata;
                i_waddr == A_MTVEC:   mtvec_d   = i_wdata;
                i_waddr == A_MEPC:    mepc_d    = i_wdata;
                i_waddr == A_MCAUSE:  mcause_d  = i_wdata;
                default: ;
            endcase
        end
        // Trap commit is applied last so it beats a same-cycle bus write.
        if (i_ecall) begin
            mepc_d   = i_ecall_pc;
            mcause_d = CSR_WD'(ECALL_MCAUSE);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mstatus_q <= CSR_WD'(MSTATUS_RST);
            mtvec_q   <= '0;
            mepc_q    <= '0;
            mcause_q  <= '0;
        end else begin
            mstatus_q <= mstatus_d;
            mtvec_q   <= mtvec_d;
            mepc_q    <= mepc_d;
            mcause_q  <= mcause_d;
        end
    end

    logic [CSR_WD-1:0] v_mstatus, v_mtvec, v_mepc, v_mcause;

`ifdef YSYX_22050710_RF_BYPASS_EN
    assign v_mstatus = mstatus_d;
    assign v_mtvec   = mtvec_d;
    assign v_mepc    = mepc_d;
    assign v_mcause  = mcause_d;
`else
    assign v_mstatus = mstatus_q;
    assign v_mtvec   = mtvec_q;
    assign v_mepc    = mepc_q;
    assign v_mcause  = mcause_q;
`endif

    always_comb begin
        o_rdata = '0;
        unique case (1'b1)
            i_raddr == A_MSTATUS: o_rdata = v_mstatus;
            i_raddr == A_MTVEC:   o_rdata = v_mtvec;
            i_raddr == A_MEPC:    o_rdata = v_mepc;
            i_raddr == A_MCAUSE:  o_rdata = v_mcause;
            default: ;
        endcase
    end

    assign o_mtvec = mtvec_q;
    assign o_mepc  = mepc_q;

endmodule

// File: rtl/ysyx_22050710_regfile.sv
// Integer register file plus machine CSRs, fed by the write-back bus.
// Bypass build option: YSYX_22050710_RF_BYPASS_EN.
module ysyx_22050710_regfile
    import ysyx_22050710_pkg::*;
#(
    parameter int GPR_ADDR_WD     = 5,
    parameter int GPR_WD          = 64,
    parameter int CSR_ADDR_WD     = 12,
    parameter int CSR_WD          = 64,
    parameter int WS_TO_RF_BUS_WD = 1 + GPR_ADDR_WD + GPR_WD
                                  + 1 + CSR_ADDR_WD + CSR_WD
) (
    input logic i_clk,
    input logic i_rst,
    ysyx_22050710_regfile_if.slave rf
);

    localparam int GPR_NUM   = 1 << GPR_ADDR_WD;
    localparam int O_CWADDR  = bus_off_csr_waddr(CSR_WD);
    localparam int O_CWEN    = bus_off_csr_wen(CSR_ADDR_WD, CSR_WD);
    localparam int O_GWDATA  = bus_off_gpr_wdata(CSR_ADDR_WD, CSR_WD);
    localparam int O_GWADDR  = bus_off_gpr_waddr(GPR_WD, CSR_ADDR_WD, CSR_WD);
    localparam int O_GWEN    = bus_off_gpr_wen(GPR_ADDR_WD, GPR_WD,
                                               CSR_ADDR_WD, CSR_WD);

    logic                   gpr_wen;
    logic [GPR_ADDR_WD-1:0] gpr_waddr;
    logic [GPR_WD-1:0]      gpr_wdata;
    logic                   csr_wen;
    logic [CSR_ADDR_WD-1:0] csr_waddr;
    logic [CSR_WD-1:0]      csr_wdata;

    assign gpr_wen   = rf.i_ws_to_rf_bus[O_GWEN];
    assign gpr_waddr = rf.i_ws_to_rf_bus[O_GWADDR +: GPR_ADDR_WD];
    assign gpr_wdata = rf.i_ws_to_rf_bus[O_GWDATA +: GPR_WD];
    assign csr_wen   = rf.i_ws_to_rf_bus[O_CWEN];
    assign csr_waddr = rf.i_ws_to_rf_bus[O_CWADDR +: CSR_ADDR_WD];
    assign csr_wdata = rf.i_ws_to_rf_bus[0 +: CSR_WD];

    logic [GPR_WD-1:0] gpr_q [GPR_NUM];
    logic [GPR_WD-1:0] gpr_d [GPR_NUM];

    always_comb begin
        gpr_d = gpr_q;
        if (gpr_wen && gpr_waddr != '0) begin
            gpr_d[gpr_waddr] = gpr_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < GPR_NUM; i++) begin
                gpr_q[i] <= '0;
            end
        end else begin
            gpr_q <= gpr_d;
        end
    end

    logic [GPR_WD-1:0] rd1_raw, rd2_raw;

`ifdef YSYX_22050710_RF_BYPASS_EN
    assign rd1_raw = gpr_d[rf.i_raddr1];
    assign rd2_raw = gpr_d[rf.i_raddr2];
`else
    assign rd1_raw = gpr_q[rf.i_raddr1];
    assign rd2_raw = gpr_q[rf.i_raddr2];
`endif

    assign rf.o_rdata1 = (rf.i_raddr1 == '0) ? '0 : rd1_raw;
    assign rf.o_rdata2 = (rf.i_raddr2 == '0) ? '0 : rd2_raw;

    ysyx_22050710_csrfile #(
        .CSR_ADDR_WD (CSR_ADDR_WD),
        .CSR_WD      (CSR_WD)
    ) u_csrfile (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_wen      (csr_wen),
        .i_waddr    (csr_waddr),
        .i_wdata    (csr_wdata),
        .i_raddr    (rf.i_csr_raddr),
        .o_rdata    (rf.o_csr_rdata),
        .i_ecall    (rf.i_ecall),
        .i_ecall_pc (rf.i_ecall_pc),
        .o_mtvec    (rf.o_mtvec),
        .o_mepc     (rf.o_mepc)
    );

endmodule

// File: tb/tb_ysyx_22050710_regfile.sv
// Directed plus random checks of the regfile against an array/map model.
// Honours YSYX_22050710_RF_BYPASS_EN for same-cycle read expectations.
module tb_ysyx_22050710_regfile;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_22050710_regfile_if rf ();

    ysyx_22050710_regfile dut (
        .i_clk (clk),
        .i_rst (rst),
        .rf    (rf)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] m_gpr [32];
    logic [63:0] m_csr [int];

    bit          p_gw, p_cw, p_ec, p_rst;
    logic [4:0]  p_ga;
    logic [11:0] p_ca;
    logic [63:0] p_gd, p_cd, p_pc;

    function automatic logic [63:0] m_rd_csr(logic [11:0] a);
        int k = int'(a);
        return m_csr.exists(k) ? m_csr[k] : 64'd0;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(bit gw, logic [4:0] ga, logic [63:0] gd,
                         bit cw, logic [11:0] ca, logic [63:0] cd,
                         bit ec, logic [63:0] pc, bit r);
        p_gw = gw; p_ga = ga; p_gd = gd;
        p_cw = cw; p_ca = ca; p_cd = cd;
        p_ec = ec; p_pc = pc; p_rst = r;
        rf.i_ws_to_rf_bus = {gw, ga, gd, cw, ca, cd};
        rf.i_ecall = ec;
        rf.i_ecall_pc = pc;
        rst = r;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_gpr[i] = 64'd0;
        m_csr.delete();
        m_csr['h300] = 64'hA_0000_1800;
        m_csr['h305] = 64'd0;
        m_csr['h341] = 64'd0;
        m_csr['h342] = 64'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (p_rst) begin
            model_reset();
        end else begin
            if (p_gw && p_ga != 0) m_gpr[p_ga] = p_gd;
            if (p_cw && m_csr.exists(int'(p_ca))) m_csr[int'(p_ca)] = p_cd;
            if (p_ec) begin
                m_csr['h341] = p_pc;
                m_csr['h342] = 64'd11;
            end
        end
        #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cyc(bit gw, logic [4:0] ga, logic [63:0] gd,
                       bit cw, logic [11:0] ca, logic [63:0] cd,
                       bit ec, logic [63:0] pc, bit r);
        drive(gw, ga, gd, cw, ca, cd, ec, pc, r);
        tick();
    endtask

    task automatic chk_gpr(string tag, logic [4:0] a1, logic [4:0] a2);
        rf.i_raddr1 = a1;
        rf.i_raddr2 = a2;
        #1;
        chk({tag, "/rd1"}, rf.o_rdata1, m_gpr[a1]);
        chk({tag, "/rd2"}, rf.o_rdata2, m_gpr[a2]);
    endtask

    task automatic chk_csr(string tag, logic [11:0] a);
        rf.i_csr_raddr = a;
        #1;
        chk({tag, "/csr"}, rf.o_csr_rdata, m_rd_csr(a));
        chk({tag, "/mtvec"}, rf.o_mtvec, m_csr['h305]);
        chk({tag, "/mepc"}, rf.o_mepc, m_csr['h341]);
    endtask

    logic [63:0] exp_v;
    logic [11:0] ra;
    logic [11:0] addrs [6];

    initial begin
        addrs[0] = 12'h300; addrs[1] = 12'h305; addrs[2] = 12'h341;
        addrs[3] = 12'h342; addrs[4] = 12'h7C0; addrs[5] = 12'h000;
        rf.i_raddr1 = 0;
        rf.i_raddr2 = 0;
        rf.i_csr_raddr = 0;
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        tick();

        chk_gpr("rst_gpr", 5'd1, 5'd31);
        chk_csr("rst_mstatus", 12'h300);
        chk_csr("rst_mcause", 12'h342);
        chk_csr("rst_unimpl", 12'h7C0);

        cyc(1, 5'd5, 64'h1234, 0, 0, 0, 0, 0, 0);
        chk_gpr("x5_write", 5'd5, 5'd0);

        cyc(1, 5'd0, 64'hFFFF, 0, 0, 0, 0, 0, 0);
        chk_gpr("x0_drop", 5'd0, 5'd5);
        tick();
        chk_gpr("x0_later", 5'd0, 5'd0);

        cyc(1, 5'd3, 64'd7, 1, 12'h305, 64'h8000_0100, 0, 0, 0);
        chk_gpr("gpr_csr_same", 5'd5, 5'd3);
        chk_csr("gpr_csr_same", 12'h305);

        cyc(0, 0, 0, 1, 12'h341, 64'hDEAD, 1, 64'h8000_0040, 0);
        chk_csr("ecall_mepc", 12'h341);
        chk_csr("ecall_mcause", 12'h342);

        cyc(0, 0, 0, 1, 12'h305, 64'h8000_0200, 1, 64'h8000_0080, 0);
        chk_csr("ecall_other_csr", 12'h305);

        // Same-cycle read of a register being written.
        cyc(1, 5'd9, 64'h11, 0, 0, 0, 0, 0, 0);
        drive(1, 5'd9, 64'h55, 1, 12'h305, 64'h777, 1, 64'h900, 0);
        rf.i_raddr1 = 5'd9;
        rf.i_csr_raddr = 12'h305;
        #1;
`ifdef YSYX_22050710_RF_BYPASS_EN
        exp_v = 64'h55;
`else
        exp_v = m_gpr[9];
`endif
        chk("bypass_gpr", rf.o_rdata1, exp_v);
`ifdef YSYX_22050710_RF_BYPASS_EN
        exp_v = 64'h777;
`else
        exp_v = m_csr['h305];
`endif
        chk("bypass_csr", rf.o_csr_rdata, exp_v);
        rf.i_csr_raddr = 12'h342;
        #1;
`ifdef YSYX_22050710_RF_BYPASS_EN
        exp_v = 64'd11;
`else
        exp_v = m_csr['h342];
`endif
        chk("bypass_mcause", rf.o_csr_rdata, exp_v);
        chk("bypass_mtvec_port", rf.o_mtvec, m_csr['h305]);
        tick();
        chk_gpr("bypass_after", 5'd9, 5'd9);
        chk_csr("bypass_after", 12'h305);

        cyc(0, 0, 0, 1, 12'h341, 64'h42, 0, 0, 0);
        chk_csr("mepc_42", 12'h341);
        cyc(1, 5'd1, 64'd1, 1, 12'h305, 64'h5, 1, 64'h99, 1);
        chk_gpr("rst_over_write", 5'd1, 5'd9);
        chk_csr("rst_over_mepc", 12'h341);
        chk_csr("rst_over_mstatus", 12'h300);
        cyc(0, 0, 0, 1, 12'h7C0, 64'hABCD, 0, 0, 0);
        chk_csr("unimpl_write", 12'h7C0);
        chk_csr("unimpl_mstatus", 12'h300);

        for (int it = 0; it < 300; it++) begin
            ra = ($urandom_range(0, 3) == 0) ? 12'($urandom)
                                             : addrs[$urandom_range(0, 5)];
            cyc($urandom_range(0, 3) != 0, 5'($urandom),
                {$urandom, $urandom},
                $urandom_range(0, 1) == 1, ra, {$urandom, $urandom},
                $urandom_range(0, 7) == 0, {$urandom, $urandom},
                $urandom_range(0, 49) == 0);
            chk_gpr("rand", 5'($urandom), 5'($urandom));
            chk_csr("rand", addrs[$urandom_range(0, 5)]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ysyx_22050710_regfile.md
YSYX_22050710_REGFILE -- requirements
Module: ysyx_22050710_regfile

Interface
REQ-001 SHALL have parameters: GPR_ADDR_WD, default 5, GPR index width; GPR_WD, default 64, GPR data width; CSR_ADDR_WD, default 12, CSR address width; CSR_WD, default 64, CSR data width; WS_TO_RF_BUS_WD, default 1+GPR_ADDR_WD+GPR_WD+1+CSR_ADDR_WD+CSR_WD, write-back bus width.
REQ-002 SHALL use one clock, i_clk; reset i_rst is synchronous and active-high.
REQ-003 i_clk  input  1  clock.
REQ-004 i_rst  input  1  synchronous active-high reset.
REQ-005 i_ws_to_rf_bus  input  WS_TO_RF_BUS_WD  write-back bus; fields MSB to LSB are gpr_wen, gpr_waddr, gpr_wdata, csr_wen, csr_waddr, csr_wdata.
REQ-006 i_raddr1, i_raddr2  input  GPR_ADDR_WD  GPR read addresses.
REQ-007 o_rdata1, o_rdata2  output  GPR_WD  GPR read data.
REQ-008 i_csr_raddr  input  CSR_ADDR_WD  CSR read address; o_csr_rdata  output  CSR_WD  CSR read data.
REQ-009 i_ecall  input  1  trap commit strobe; i_ecall_pc  input  CSR_WD  PC of the trapping instruction.
REQ-010 o_mtvec, o_mepc  output  CSR_WD  live trap vector and return address.

Function
REQ-011 SHALL unpack i_ws_to_rf_bus in exactly the field order of REQ-005.
REQ-012 GPR file: 2^GPR_ADDR_WD entries; write on rising i_clk when gpr_wen=1 and gpr_waddr!=0; x0 reads 0 always; writes to x0 are dropped.
REQ-013 GPR reads are combinational, zero latency.
REQ-014 CSRs implemented: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342; all are full-width read/write.
REQ-015 A CSR write takes effect on the rising i_clk edge when csr_wen=1 and csr_waddr is implemented; writes to unimplemented addresses are ignored.
REQ-016 Reads of unimplemented CSR addresses return 0.
REQ-017 On i_ecall=1, the same edge SHALL set mepc<=i_ecall_pc and mcause<=11.
REQ-018 If i_ecall and a bus CSR write target the same mepc/mcause register in one cycle, the ecall value wins; a bus write to any other CSR in that cycle still lands.
REQ-019 A GPR write and a CSR write on the same cycle SHALL both commit.
REQ-020 o_mtvec/o_mepc reflect register contents (post-edge), independent of i_csr_raddr.

Reset
REQ-021 On i_rst=1 at a clock edge: all GPRs 0, mstatus 0xA00001800, mtvec/mepc/mcause 0; reset overrides any write or ecall in the same cycle.
REQ-022 After reset: o_rdata1/2=0, o_mtvec=o_mepc=0, o_csr_rdata=0xA00001800 when addressing mstatus, else 0.

Configuration
REQ-023 Macro YSYX_22050710_RF_BYPASS_EN: when defined, a GPR read whose address equals an active nonzero gpr_waddr returns gpr_wdata in the same cycle, and a CSR read hitting an active csr_waddr returns csr_wdata, or the ecall value for mepc/mcause.
REQ-024 Without the macro, reads return stored contents only; new data is visible the cycle after the write.

Structure
REQ-025 Package ysyx_22050710_pkg SHALL hold CSR address constants, the mstatus reset value, the ecall mcause code 11, and bus field offset constants.
REQ-026 CSR storage, trap update and CSR read mux SHALL live in sub-module ysyx_22050710_csrfile; GPR array and bus unpack stay in the top.

Verification
REQ-027 Reset, then write x5=0x1234 via bus -> next cycle o_rdata1 (raddr1=5) = 0x1234.
REQ-028 Bus write x0=0xFFFF -> o_rdata1 (raddr1=0) = 0 forever.
REQ-029 Same cycle: gpr x3=7 and csr mtvec=0x80000100 -> next cycle o_rdata2=7, o_mtvec=0x80000100.
REQ-030 i_ecall=1, i_ecall_pc=0x80000040, concurrent bus write mepc=0xDEAD -> o_mepc=0x80000040, mcause=11.
REQ-031 Raddr1=9 while writing x9=0x55: with YSYX_22050710_RF_BYPASS_EN o_rdata1=0x55 same cycle; without it old value, 0x55 next cycle.
REQ-032 Write mepc=0x42, then assert i_rst with concurrent write x1=1 -> mepc=0, x1=0, mstatus=0xA00001800; csr write 0x7C0 -> reads 0.
